mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, RAM word-address width.
REQ-002 Parameter DATA_W, default 16, RAM data width.
REQ-003 Parameter STARVE_LIMIT, default 8, range 1..255, consecutive denied loader-request cycles before the loader is forced a grant.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 core_req  input  1  core requests an access this cycle.
REQ-007 core_we  input  1  core access is a write (1) or a read (0).
REQ-008 core_addr  input  ADDR_W  core word address.
REQ-009 core_wdata  input  DATA_W  core write data.
REQ-010 core_gnt  output  1  core access is accepted this cycle.
REQ-011 core_rvalid  output  1  core read data is valid on rdata this cycle.
REQ-012 ld_req, ld_we, ld_addr, ld_wdata  input  1/1/ADDR_W/DATA_W  loader equivalents of REQ-006..009.
REQ-013 ld_gnt, ld_rvalid  output  1/1  loader equivalents of REQ-010..011.
REQ-014 rdata  output  DATA_W  read data shared by both requesters; equals ram_dout.
REQ-015 ram_we  output  1  RAM port-A write enable.
REQ-016 ram_addr  output  ADDR_W  RAM port-A address.
REQ-017 ram_din  output  DATA_W  RAM port-A write data.
REQ-018 ram_dout  input  DATA_W  RAM port-A read data, valid one clk after the address edge.

Function
REQ-019 Grant decision SHALL be combinational within the request cycle; at most one of core_gnt and ld_gnt SHALL be high in any cycle.
REQ-020 Priority SHALL be:
  - if ld_req and starve_cnt == STARVE_LIMIT, the loader wins;
  - otherwise, if core_req, the core wins;
  - otherwise, if ld_req, the loader wins;
  - otherwise, no grant.
REQ-021 The granted requester's we/addr/wdata SHALL drive ram_we/ram_addr/ram_din in the same cycle.
REQ-022 In a cycle with no grant, ram_we SHALL be 0, ram_addr 0 and ram_din 0.
REQ-023 starve_cnt (8 bits) SHALL increment when ld_req=1 and ld_gnt=0, saturating at STARVE_LIMIT.
REQ-024 starve_cnt SHALL clear to 0 on any cycle with ld_gnt=1 or ld_req=0.
REQ-025 A granted read in cycle N SHALL assert the matching *_rvalid for exactly cycle N+1, with rdata = ram_dout; a granted write SHALL assert no rvalid.
REQ-026 Read-return tracking SHALL use two registered flags, rd_core and rd_ld, loaded every cycle from (grant & ~we) per requester.
REQ-027 Back-to-back granted reads SHALL sustain one return per cycle, in grant order.
REQ-028 A write and a read to the same address in consecutive cycles SHALL return the RAM's port-A read-after-write result; no bypass is provided.
REQ-029 A request that is not granted SHALL have no side effect; the requester holds req/we/addr/wdata until it sees gnt.

Reset
REQ-030 While reset_n=0: core_gnt=0, ld_gnt=0, ram_we=0, core_rvalid=0, ld_rvalid=0, starve_cnt=0, rd_core=0, rd_ld=0.
REQ-031 Reset asserted mid-read SHALL cancel the pending return: no rvalid after reset_n rises.
REQ-032 The first grant after reset SHALL be possible in the first clk edge cycle with reset_n=1.

Verification
REQ-033 Core read only: core_req=1, core_we=0, core_addr=0x0010 with RAM[0x10]=0xBEEF -> core_gnt same cycle, core_rvalid=1 and rdata=0xBEEF next cycle only.
REQ-034 Simultaneous requests, STARVE_LIMIT=8: core_req and ld_req held high for 20 cycles -> core granted 8 cycles, loader granted the 9th, then the pattern repeats; grants never overlap.
REQ-035 Loader write, core idle: ld_we=1, ld_addr=0x1234, ld_wdata=0x00A5 -> ld_gnt=1, ram_we=1, ram_addr=0x1234, ram_din=0x00A5 same cycle; a later core read of 0x1234 returns 0x00A5.
REQ-036 Interleaved returns: core read at cycle N, loader read at N+1 -> core_rvalid at N+1 only, ld_rvalid at N+2 only.
REQ-037 Reset mid-read: core read granted at cycle N, reset_n low during N+1 -> core_rvalid stays 0; all outputs hold reset values while low.
REQ-038 Starvation counter clear: ld_req high 5 cycles against core, then low 1 cycle, then high again -> loader forced grant only after 8 further denied cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between a core and a loader, with core priority and loader starvation relief.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  logic [7:0] r_starve_cnt;
  logic       r_rd_core;
  logic       r_rd_ld;
  logic       w_force;
  assign w_force     = ld_req && (r_starve_cnt == 8'(STARVE_LIMIT));
  // Grants are gated by reset_n so nothing reaches the RAM while reset is held.
  assign core_gnt    = reset_n && core_req && !w_force;
  assign ld_gnt      = reset_n && ld_req && (w_force || !core_req);
  assign ram_we      = (core_gnt && core_we) || (ld_gnt && ld_we);
  assign ram_addr    = core_gnt ? core_addr : ld_gnt ? ld_addr : '0;
  assign ram_din     = core_gnt ? core_wdata : ld_gnt ? ld_wdata : '0;
  assign core_rvalid = r_rd_core;
  assign ld_rvalid   = r_rd_ld;
  assign rdata       = ram_dout;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
      r_rd_core    <= 1'b0;
      r_rd_ld      <= 1'b0;
    end else begin
      r_rd_core    <= core_gnt && !core_we;
      r_rd_ld      <= ld_gnt && !ld_we;
      r_starve_cnt <= (!ld_req || ld_gnt) ? '0 :
                      (r_starve_cnt == 8'(STARVE_LIMIT)) ? r_starve_cnt : r_starve_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for starvation and reset corners.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req, core_we, ld_req, ld_we;
  logic [15:0] core_addr, core_wdata, ld_addr, ld_wdata;
  logic        core_gnt, core_rvalid, ld_gnt, ld_rvalid, ram_we;
  logic [15:0] rdata, ram_addr, ram_din, ram_dout;
  logic [15:0] mem [0:65535];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .rdata(rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        cr, cw; logic [15:0] ca, cd;
    logic        lr, lw; logic [15:0] la, ld;
    logic        e_cg, e_lg, e_we; logic [15:0] e_addr, e_din;
    logic        e_crv, e_lrv; logic [15:0] e_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cr, cw, input logic [15:0] ca, cd,
                       input logic lr, lw, input logic [15:0] la, ld);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [12];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0010] = 16'hBEEF;
    ram_dout = 16'h0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    tbl[0]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,16'h0000};
    tbl[1]  = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,16'h0010,16'h0000, 0,0,16'h0000};
    tbl[2]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,16'hBEEF};
    tbl[3]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,16'h0000};
    tbl[4]  = '{0,0,16'h0000,16'h0000, 1,1,16'h1234,16'h00A5, 0,1,1,16'h1234,16'h00A5, 0,0,16'h0000};
    tbl[5]  = '{1,0,16'h1234,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,16'h1234,16'h0000, 0,0,16'h0000};
    tbl[6]  = '{0,0,16'h0000,16'h0000, 1,0,16'h1234,16'h0000, 0,1,0,16'h1234,16'h0000, 1,0,16'h00A5};
    tbl[7]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,1,16'h00A5};
    tbl[8]  = '{1,1,16'h0020,16'h5555, 0,0,16'h0000,16'h0000, 1,0,1,16'h0020,16'h5555, 0,0,16'h0000};
    tbl[9]  = '{1,0,16'h0020,16'h7777, 1,0,16'h0030,16'h9999, 1,0,0,16'h0020,16'h7777, 0,0,16'h0000};
    tbl[10] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,16'h5555};
    tbl[11] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,16'h0000};

    #12;
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #4;

    foreach (tbl[i]) begin
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].lr, tbl[i].lw, tbl[i].la, tbl[i].ld);
      #1;
      chk($sformatf("v%0d_core_gnt", i), core_gnt, tbl[i].e_cg);
      chk($sformatf("v%0d_ld_gnt", i), ld_gnt, tbl[i].e_lg);
      chk($sformatf("v%0d_ram_we", i), ram_we, tbl[i].e_we);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_ram_din", i), ram_din, tbl[i].e_din);
      chk($sformatf("v%0d_core_rvalid", i), core_rvalid, tbl[i].e_crv);
      chk($sformatf("v%0d_ld_rvalid", i), ld_rvalid, tbl[i].e_lrv);
      if (tbl[i].e_crv || tbl[i].e_lrv) chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
      tick();
    end

    // Both requesters held: core wins 8 cycles, loader forced on the 9th, repeating.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 16'h0040, 0, 1, 0, 16'h0050, 0);
      #1;
      chk($sformatf("starve%0d_ld_gnt", i), ld_gnt, (i == 8 || i == 17));
      chk($sformatf("starve%0d_core_gnt", i), core_gnt, !(i == 8 || i == 17));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Loader denied 5 cycles, drops for one, then needs 8 more denials before relief.
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 16'h0040, 0, (i != 5), 0, 16'h0050, 0);
      #1;
      chk($sformatf("clr%0d_ld_gnt", i), ld_gnt, (i == 14));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset asserted while a core read return is pending.
    drive(1, 0, 16'h0010, 0, 0, 0, 0, 0);
    #1;
    chk("rr_core_gnt", core_gnt, 1);
    tick();
    reset_n = 1'b0;
    drive(1, 0, 16'h0010, 0, 1, 1, 16'h0060, 16'h1111);
    #1;
    chk("rr_low_core_rvalid", core_rvalid, 0);
    chk("rr_low_core_gnt", core_gnt, 0);
    chk("rr_low_ld_gnt", ld_gnt, 0);
    chk("rr_low_ram_we", ram_we, 0);
    tick();
    chk("rr_low2_ld_rvalid", ld_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk("rr_rel_core_rvalid", core_rvalid, 0);
    tick();
    chk("rr_after_core_rvalid", core_rvalid, 0);
    drive(1, 0, 16'h0010, 0, 0, 0, 0, 0);
    #1;
    chk("first_gnt_after_rst", core_gnt, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("first_rd_rvalid", core_rvalid, 1);
    chk("first_rd_rdata", rdata, 16'hBEEF);
    tick();
    chk("first_rd_rvalid_drop", core_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
